// File: rtl/risc_eu_param.sv
// risc_eu_param: parameterised RISC16 execution unit with PC, IR, 8-entry
// register file, ALU/zero flag and its own fetch/execute sequencer on a req/ack memory port.
module risc_eu_param #(
  parameter int            DW         = 16,
  parameter int            AW         = 16,
  parameter logic [AW-1:0] RST_VECTOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [DW-1:0] Din,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] Addr_Out,
  output logic [DW-1:0] Dout,
  output logic          halted,
  output logic          zflag
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_BRA  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [15:0]   ir_q, ir_d;
  logic          z_q, z_d, req_q, req_d, we_q, we_d, halt_q, halt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] rf_q [8];
  logic          rf_we;
  logic [DW-1:0] rf_wd;

  logic [3:0]    op;
  logic [2:0]    rd, rs;
  logic [DW-1:0] rd_val, rs_val, imm6_x, imm9_x, alu_res;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:9];
  assign rs     = ir_q[8:6];
  assign rd_val = rf_q[rd];
  assign rs_val = rf_q[rs];
  assign imm6_x = {{(DW-6){ir_q[5]}}, ir_q[5:0]};
  assign imm9_x = {{(DW-9){ir_q[8]}}, ir_q[8:0]};

  // LDI shares the ALU writeback/flag path
  always_comb begin
    case (op)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_OR:   alu_res = rd_val | rs_val;
      OP_XOR:  alu_res = rd_val ^ rs_val;
      OP_LDI:  alu_res = imm6_x;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    rf_we   = 1'b0;
    rf_wd   = alu_res;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: if (mem_ack) begin
        ir_d    = Din[15:0];
        pc_d    = pc_q + AW'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
            rf_we = 1'b1;
            z_d   = (alu_res == '0);
          end
          OP_JMP:  pc_d = rs_val[AW-1:0];
          OP_BZ:   if (z_q) pc_d = pc_q + imm9_x[AW-1:0];
          OP_BRA:  pc_d = pc_q + imm9_x[AW-1:0];
          default: ;
        endcase
        if (op == OP_LD || op == OP_ST) state_d = S_MEM;
        else if (op == OP_HALT)         state_d = S_HALT;
        else                            state_d = run ? S_FETCH : S_IDLE;
      end
      S_MEM: if (mem_ack) begin
        if (op == OP_LD) begin
          rf_we = 1'b1;
          rf_wd = Din;
          z_d   = (Din == '0);
        end
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
    // Bus outputs follow the next state so they are registered yet valid on entry
    req_d  = (state_d == S_FETCH) || (state_d == S_MEM);
    we_d   = (state_d == S_MEM) && (op == OP_ST);
    addr_d = (state_d == S_MEM) ? rs_val[AW-1:0] : pc_d;
    dout_d = we_d ? rd_val : '0;
    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RST_VECTOR;
      ir_q    <= '0;
      z_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      halt_q  <= 1'b0;
      addr_q  <= RST_VECTOR;
      dout_q  <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      req_q   <= req_d;
      we_q    <= we_d;
      halt_q  <= halt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      if (rf_we) rf_q[rd] <= rf_wd;
    end
  end

  assign mem_req  = req_q;
  assign mem_we   = we_q;
  assign Addr_Out = addr_q;
  assign Dout     = dout_q;
  assign halted   = halt_q;
  assign zflag    = z_q;
endmodule

// File: tb/tb_risc_eu_param.sv
// Bench for risc_eu_param: wait-state memory responder, ISA-level reference
// model producing the expected bus trace, plus directed timing/run/reset cases.
module tb_risc_eu_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, ack, req, we, halted, zflag;
  logic [15:0] din, addr, dout;
  logic        rst2, run2, ack2, req2, we2, halted2, z2;
  logic [31:0] din2, dout2;
  logic [11:0] addr2;

  risc_eu_param dut (
    .clk(clk), .rst(rst), .run(run), .Din(din), .mem_ack(ack), .mem_req(req),
    .mem_we(we), .Addr_Out(addr), .Dout(dout), .halted(halted), .zflag(zflag));

  risc_eu_param #(.DW(32), .AW(12), .RST_VECTOR(12'hFFF)) dut2 (
    .clk(clk), .rst(rst2), .run(run2), .Din(din2), .mem_ack(ack2), .mem_req(req2),
    .mem_we(we2), .Addr_Out(addr2), .Dout(dout2), .halted(halted2), .zflag(z2));

  typedef struct { logic [63:0] w; bit fetch; bit z; } acc_t;
  acc_t        exp_q[$];
  logic [15:0] mem [65536];
  logic [15:0] mm  [65536];
  logic [31:0] mem2 [4096];
  logic [11:0] f2_q[$];
  logic [11:0] st2_a;
  logic [31:0] st2_d;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          maxw;
  bit          fixedw, strict, exp_halt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  // ISA-level model: walks the program and lists every bus access it must make
  task automatic build_trace(input int maxi);
    int unsigned r [8];
    int unsigned res;
    logic [15:0] pc, ins, off, ea;
    logic [3:0]  op;
    logic [2:0]  rd, rs;
    bit          z;
    exp_q.delete();
    for (int a = 0; a < 65536; a++) mm[a] = mem[a];
    for (int i = 0; i < 8; i++) r[i] = 0;
    pc = 16'h0; z = 1'b0; exp_halt = 1'b0;
    for (int n = 0; n < maxi && !exp_halt; n++) begin
      exp_q.push_back('{{32'd0, pc, 16'd0}, 1'b1, z});
      ins = mm[pc];
      pc  = pc + 16'd1;
      op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6];
      off = ins[8] ? {7'h7F, ins[8:0]} : {7'h00, ins[8:0]};
      ea  = 16'(r[rs]);
      res = r[rd];
      case (op)
        4'h1: res = r[rd] + r[rs];
        4'h2: res = r[rd] - r[rs];
        4'h3: res = r[rd] & r[rs];
        4'h4: res = r[rd] | r[rs];
        4'h5: res = r[rd] ^ r[rs];
        4'h6: res = ins[5] ? (32'hFFC0 | 32'(ins[5:0])) : 32'(ins[5:0]);
        4'h7: begin
          exp_q.push_back('{{32'd0, ea, 16'd0}, 1'b0, 1'b0});
          res = 32'(mm[ea]);
        end
        4'h8: begin
          exp_q.push_back('{{31'd0, 1'b1, ea, 16'(r[rd])}, 1'b0, 1'b0});
          mm[ea] = 16'(r[rd]);
        end
        4'h9: pc = ea;
        4'hA: if (z) pc = pc + off;
        4'hB: pc = pc + off;
        4'hF: exp_halt = 1'b1;
        default: ;
      endcase
      if (op >= 4'h1 && op <= 4'h7) begin
        r[rd] = res & 32'hFFFF;
        z = (r[rd] == 0);
      end
    end
  endtask

  // Memory responder for the 16-bit unit: random waits, stray acks while idle
  initial begin
    int          wcnt;
    bit          in_acc;
    logic [32:0] cur, hold;
    acc_t        e;
    ack = 1'b0; din = '0; in_acc = 1'b0; wcnt = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (rst || !req) begin
        in_acc = 1'b0;
        ack    = 1'($urandom_range(0, 1));
        din    = 16'($urandom);
      end else begin
        cur = {we, addr, dout};
        if (!in_acc) begin
          in_acc = 1'b1;
          hold   = cur;
          wcnt   = fixedw ? maxw : $urandom_range(0, maxw);
        end else chk("hold", 64'(cur), 64'(hold));
        if (wcnt == 0) begin
          ack    = 1'b1;
          din    = we ? 16'($urandom) : mem[addr];
          in_acc = 1'b0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("acc", {31'd0, cur}, e.w);
            if (e.fetch) chk("zflag", 64'(zflag), 64'(e.z));
          end else if (strict) chk("extra_acc", 64'(req), 64'd0);
          if (we) mem[addr] = dout;
        end else begin
          ack  = 1'b0;
          wcnt = wcnt - 1;
          din  = 16'($urandom);
        end
      end
    end
  end

  // Zero-wait responder for the 32-bit/12-bit unit
  initial begin
    ack2 = 1'b0; din2 = '0; st2_a = '0; st2_d = '0;
    forever begin
      @(negedge clk);
      ack2 = req2 && !rst2;
      din2 = mem2[addr2];
      if (req2 && !rst2) begin
        if (we2) begin st2_a = addr2; st2_d = dout2; mem2[addr2] = dout2; end
        else f2_q.push_back(addr2);
      end
    end
  end

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
  endtask

  task automatic start_prog(input int maxi);
    strict = 1'b0; run = 1'b0; rst = 1'b1;
    build_trace(maxi);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; strict = 1'b1; run = 1'b1;
  endtask

  task automatic finish_prog(input int budget, input string tag);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
    chk({tag, "_done"}, 64'(exp_q.size()), 64'd0);
    if (exp_halt) begin
      repeat (20) @(posedge clk);
      #1;
      chk({tag, "_halt"}, {62'd0, halted, req}, 64'd2);
    end
    strict = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_q(input int n, input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() <= n) break;
      nclk();
    end
    chk(tag, 64'(exp_q.size() <= n), 64'd1);
  endtask

  task automatic wait_req(input bit want_wait, input string tag);
    int i;
    for (i = 0; i < 50; i++) begin
      nclk();
      if (req && (!want_wait || !ack)) break;
    end
    chk(tag, 64'(i < 50), 64'd1);
  endtask

  initial begin
    logic [35:0] fs;
    rst = 1'b1; run = 1'b0; strict = 1'b0; maxw = 0; fixedw = 1'b1; exp_halt = 1'b0;
    rst2 = 1'b1; run2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {28'd0, req, we, halted, zflag, addr, dout}, 64'd0);
    chk("rst2_out", {req2, we2, halted2, z2, addr2}, {4'b0, 12'hFFF});

    // LDI r1,5 then ST r1,[r1]: 2-cycle LDI, next fetch at 1
    clear_mem();
    mem[0] = 16'h6205; mem[1] = 16'h8240; mem[2] = 16'hF000;
    maxw = 0; fixedw = 1'b1;
    start_prog(20);
    wait_req(1'b0, "ldi_start");
    nclk(); nclk();
    chk("ldi_pc", {req, zflag, addr}, {1'b1, 1'b0, 16'd1});
    finish_prog(200, "ldi");
    chk("ldi_st", 64'(mem[5]), 64'h5);

    // LDI r1,5; LDI r2,5; SUB r1,r2 -> zero after 6 cycles
    clear_mem();
    mem[0] = 16'h6205; mem[1] = 16'h6405; mem[2] = 16'h2280;
    mem[3] = 16'h8200; mem[4] = 16'hF000;
    start_prog(20);
    wait_req(1'b0, "sub_start");
    repeat (6) nclk();
    chk("sub_6cyc", {req, zflag, addr}, {1'b1, 1'b1, 16'd3});
    finish_prog(200, "sub");

    // 0xFFFF + 1 wraps to 0
    clear_mem();
    mem[0] = 16'h623F; mem[1] = 16'h6401; mem[2] = 16'h1280;
    mem[3] = 16'h8200; mem[4] = 16'hF000;
    start_prog(20);
    finish_prog(200, "addwrap");
    chk("addwrap_z", {63'd0, zflag}, 64'd1);

    // Store/load through r3=0x10 with two wait cycles per access
    clear_mem();
    mem[0] = 16'h6610; mem[1] = 16'h683F; mem[2] = 16'h88C0;
    mem[3] = 16'h7AC0; mem[4] = 16'h8A00; mem[5] = 16'hF000;
    maxw = 2; fixedw = 1'b1;
    start_prog(20);
    finish_prog(400, "ldst");
    chk("ldst_mem", {32'd0, mem[16'h10], mem[0]}, {32'd0, 16'hFFFF, 16'hFFFF});

    // Branches: BRA +2, BZ -2 taken/untaken, BRA +0, JMP r2=0x100 self-loop
    clear_mem();
    mem[0] = 16'h6200; mem[1] = 16'hB002; mem[3] = 16'h6201; mem[4] = 16'hA1FE;
    mem[5] = 16'hB000; mem[6] = 16'h6410;
    for (int a = 7; a < 11; a++) mem[a] = 16'h1480;
    mem[11] = 16'h9080; mem[16'h100] = 16'h9080;
    maxw = 1; fixedw = 1'b0;
    start_prog(30);
    finish_prog(400, "branch");

    // Drop run during a LD wait: LD completes, unit parks at PC=1
    clear_mem();
    mem[0] = 16'h7200; mem[1] = 16'h8200; mem[2] = 16'hF000;
    maxw = 3; fixedw = 1'b1;
    start_prog(20);
    wait_q(4, "rdrop_f0");
    wait_req(1'b1, "rdrop_mem");
    run = 1'b0;
    wait_q(3, "rdrop_ld");
    repeat (3) nclk();
    chk("park", {req, addr}, {1'b0, 16'd1});
    repeat (5) nclk();
    chk("park_hold", {req, halted, addr}, {2'b0, 16'd1});
    run = 1'b1;
    finish_prog(200, "rdrop");

    // Async reset between edges during a fetch wait
    clear_mem();
    mem[0] = 16'h6205; mem[1] = 16'h8240; mem[2] = 16'hF000;
    start_prog(20);
    wait_q(3, "arst_f0");
    wait_req(1'b1, "arst_wait");
    #2 rst = 1'b1;
    #1 chk("arst", {req, we, halted, zflag, addr}, {4'b0, 16'h0});
    strict = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; run = 1'b0;

    // Random programs, random wait states
    for (int k = 0; k < 6; k++) begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      maxw = $urandom_range(0, 3); fixedw = 1'b0;
      start_prog(150);
      finish_prog(2000, "rand");
    end
    run = 1'b0; rst = 1'b1;

    // DW=32/AW=12 unit: reset vector 0xFFF, PC wraps to 0
    for (int a = 0; a < 4096; a++) mem2[a] = 32'h0;
    mem2[12'hFFF] = 32'h623F; mem2[0] = 32'h8280; mem2[1] = 32'hF000;
    @(negedge clk);
    rst2 = 1'b0; run2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nclk();
      if (req2) break;
    end
    #2 rst2 = 1'b1;
    #1 chk("arst2", {req2, addr2}, {1'b0, 12'hFFF});
    f2_q.delete();
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 50 && !halted2; i++) nclk();
    fs = '1;
    for (int i = 0; i < f2_q.size() && i < 3; i++) fs[i*12 +: 12] = f2_q[i];
    chk("wrap_seq", {20'd0, 8'(f2_q.size()), fs}, {20'd0, 8'd3, 12'h001, 12'h000, 12'hFFF});
    chk("st2", {20'd0, st2_a, st2_d}, {20'd0, 12'h000, 32'hFFFF_FFFF});
    chk("halt2", {62'd0, halted2, z2}, 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
